// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply-divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        write_hi;
  logic        write_lo;
  logic [31:0] write_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, write_hi, write_lo, write_data,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, write_hi, write_lo, write_data,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; signs applied in FIX.
module mult_div_unit (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;      // mult: running product; div: {remainder, quotient}
  logic [31:0] opb_q;      // multiplicand / divisor magnitude
  logic        div_q;      // operation is a divide
  logic        neg_res_q;  // product / quotient must be negated
  logic        neg_rem_q;  // remainder takes dividend sign
  logic        zdiv_q;     // divide with zero divisor
  logic [31:0] hi_q, lo_q;
  logic        done_q, dbz_q;

  // Accept-time operand conditioning
  logic        is_signed, is_div, a_neg, b_neg, b_zero, accept, idle_wr;
  logic [31:0] a_mag, b_mag;

  assign is_signed = ~bus.op[0];
  assign is_div    = bus.op[1];
  assign a_neg     = is_signed & bus.operand_a[31];
  assign b_neg     = is_signed & bus.operand_b[31];
  assign a_mag     = a_neg ? (32'd0 - bus.operand_a) : bus.operand_a;
  assign b_mag     = b_neg ? (32'd0 - bus.operand_b) : bus.operand_b;
  assign b_zero    = (bus.operand_b == 32'd0);
  assign accept    = (state_q == IDLE) && bus.start;
  assign idle_wr   = (state_q == IDLE) && !bus.start;

  // One iteration of each algorithm, selected by div_q in CALC
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift, div_diff;
  logic [63:0] div_next;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next  = {mul_sum, acc_q[31:1]};
  assign div_shift = acc_q[63:31];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                  : {div_diff[31:0],  acc_q[30:0], 1'b1};

  // Sign fix-up of the raw magnitudes
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, a_raw;

  assign prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
  assign quo_fix  = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  // Zero-divisor skips CALC, so acc_q still holds the dividend magnitude
  assign a_raw    = neg_rem_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: zero divisor jumps straight to FIX
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (is_div && b_zero) ? FIX : CALC;
      CALC:    if (cnt_q == 6'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch at accept, then iterate in CALC
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zdiv_q    <= 1'b0;
    end else if (accept) begin
      cnt_q     <= 6'd0;
      acc_q     <= {32'd0, is_div ? a_mag : b_mag};
      opb_q     <= is_div ? b_mag : a_mag;
      div_q     <= is_div;
      neg_res_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      zdiv_q    <= is_div && b_zero;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 6'd1;
      acc_q <= div_q ? div_next : mul_next;
    end
  end

  // HI/LO: result write in FIX, MTHI/MTLO only when idle and not starting
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (state_q == FIX) begin
      if (zdiv_q) begin
        hi_q <= a_raw;
        lo_q <= 32'hFFFF_FFFF;
      end else if (div_q) begin
        hi_q <= rem_fix;
        lo_q <= quo_fix;
      end else begin
        hi_q <= prod_fix[63:32];
        lo_q <= prod_fix[31:0];
      end
    end else if (idle_wr) begin
      if (bus.write_hi) hi_q <= bus.write_data;
      if (bus.write_lo) lo_q <= bus.write_data;
    end
  end

  // Completion pulse follows the FIX edge; reset kills it
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= (state_q == FIX);
      dbz_q  <= (state_q == FIX) && zdiv_q;
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule
